keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//   Scans a 4x4 matrix keypad: drives one column low at a time and samples the active-low rows.
//   Sequences the external debouncer through enable, clear, criterion and period.
//   Emits exactly one key_valid pulse per debounced press, and re-arms only after a debounced release.
//   Sits between the keypad pins and the display/key-decode logic.
// PARAMETERS
//   SETTLE_CYCLES    16         clk cycles a newly driven column settles before rows are sampled (>=1)
//   DEBOUNCE_CYCLES  32'd60000  value driven on db_period for the debouncer
// PORTS
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-high reset
//   rows_n        in   4   raw keypad rows, active low, asynchronous to clk
//   cols_n        out  4   column drive, active low, one-hot-low
//   db_en         out  1   debouncer count enable
//   db_clear      out  1   debouncer reset, 1-cycle pulse
//   db_criterion  out  4   row pattern the debouncer must see held
//   db_period     out  32  debounce period; constant DEBOUNCE_CYCLES
//   db_steady     in   1   debouncer reports criterion held for db_period
//   key_code      out  4   {row_idx[1:0], col_idx[1:0]} of last accepted key
//   key_valid     out  1   1-cycle pulse when key_code updates
//   key_held      out  1   high from accept until debounced release
// BEHAVIOUR
//   Row synchronizer
//     - rows_n passes through a 2-flop synchronizer (rows_s); reset value 4'b1111.
//     - All decisions below use rows_s.
//   Reset values (all outputs, every state register)
//     - cols_n=4'b1110, col_idx=0, state=SCAN, settle counter=0.
//     - db_en=0, db_clear=1, db_criterion=4'b1111, key_code=0, key_valid=0, key_held=0.
//     - Reset mid-operation aborts any press in progress; no key_valid is generated.
//   SCAN
//     - The settle counter counts SETTLE_CYCLES cycles; rows_s is sampled on the following cycle.
//     - Every column is therefore driven for SETTLE_CYCLES+1 cycles.
//     - rows_s==4'b1111: advance col_idx (3 wraps to 0), clear the settle counter.
//     - rows_s has exactly one zero: capture row_idx and col_idx, set db_criterion=rows_s.
//       Pulse db_clear for 1 cycle, then go to PRESS_DB.
//     - rows_s has two or more zeros: ghost/multi-key; advance the column as for no key.
//     - db_en=0 throughout SCAN.
//   PRESS_DB
//     - cols_n is frozen and db_en=1.
//     - rows_s != db_criterion: abort. Pulse db_clear, set db_en=0, advance the column, return to SCAN.
//     - db_steady=1 (first cycle):
//       key_code={row_idx,col_idx}; key_valid=1 on the next cycle only.
//       key_held=1, db_en=0, go to HELD.
//     - An abort and db_steady in the same cycle: db_steady wins.
//   HELD
//     - cols_n is frozen; key_held=1.
//     - Additional rows pressed in the frozen column are ignored.
//     - rows_s==4'b1111: db_criterion=4'b1111; pulse db_clear, then go to REL_DB.
//   REL_DB
//     - db_en=1.
//     - rows_s != 4'b1111: go back to HELD, with db_en=0 and no new key_valid.
//     - db_steady=1: key_held=0, db_en=0, advance the column, go to SCAN.
//   Rules that hold in every state
//     - key_valid never asserts two consecutive cycles.
//     - key_code holds its value between accepts.
//     - The settle counter is $clog2(SETTLE_CYCLES+1) bits and never wraps.
// TESTING
//   Common setup: SETTLE_CYCLES=4; the debouncer model asserts db_steady after 8 matching enabled cycles.
//   1. Idle scan: rows_n=4'b1111 after reset -> cols_n steps 1110,1101,1011,0111,1110, 5 cycles each; key_valid stays 0.
//   2. Clean press row2/col1: rows_n=4'b1011 while cols_n=1101 -> exactly one key_valid pulse; key_code=4'b1001; key_held=1.
//   3. Bounce: row0 low for 3 cycles then high -> db_clear pulses on abort; no key_valid; scanning resumes at the next column.
//   4. Ghost: rows_n=4'b1001 during col2 -> no PRESS_DB entry; key_valid stays 0.
//   5. Release bounce: in HELD, release, re-press within 4 cycles -> back to HELD, no second pulse.
//      A clean release after that -> key_held falls; scanning resumes at the next column.
//   6. Reset asserted in HELD -> next cycle shows all reset values; a still-held key is re-detected once as a new press.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks an active-low column, samples synchronized rows,
// and sequences an external debouncer to accept exactly one key per debounced press/release.
module keypad_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd60000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows_n,
  output logic [3:0]  cols_n,
  output logic        db_en,
  output logic        db_clear,
  output logic [3:0]  db_criterion,
  output logic [31:0] db_period,
  input  logic        db_steady,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_HELD     = 2'd2,
    S_REL_DB   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       rows_meta_q;
  logic [3:0]       rows_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic             db_en_q, db_en_d;
  logic             db_clear_q, db_clear_d;
  logic [3:0]       db_criterion_q, db_criterion_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic       single_low;
  logic [1:0] row_enc;
  logic       cnt_done;
  logic       rows_idle;
  logic       press_abort;
  logic       steady_ok;

  // Exactly one low row identifies a key; zero or several lows are treated as no key.
  always_comb begin
    single_low = 1'b1;
    row_enc    = 2'd0;
    case (rows_s_q)
      4'b1110: row_enc = 2'd0;
      4'b1101: row_enc = 2'd1;
      4'b1011: row_enc = 2'd2;
      4'b0111: row_enc = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  assign cnt_done    = (cnt_q == SETTLE_MAX);
  assign rows_idle   = (rows_s_q == 4'b1111);
  assign press_abort = (rows_s_q != db_criterion_q);
  // While the debouncer is being cleared its steady flag still reflects the previous run.
  assign steady_ok   = db_steady && !db_clear_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta_q    <= 4'b1111;
      rows_s_q       <= 4'b1111;
      state_q        <= S_SCAN;
      cnt_q          <= '0;
      col_idx_q      <= 2'd0;
      row_idx_q      <= 2'd0;
      db_en_q        <= 1'b0;
      db_clear_q     <= 1'b1;
      db_criterion_q <= 4'b1111;
      key_code_q     <= 4'd0;
      key_valid_q    <= 1'b0;
      key_held_q     <= 1'b0;
    end else begin
      rows_meta_q    <= rows_n;
      rows_s_q       <= rows_meta_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      col_idx_q      <= col_idx_d;
      row_idx_q      <= row_idx_d;
      db_en_q        <= db_en_d;
      db_clear_q     <= db_clear_d;
      db_criterion_q <= db_criterion_d;
      key_code_q     <= key_code_d;
      key_valid_q    <= key_valid_d;
      key_held_q     <= key_held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SCAN: begin
        if (cnt_done && single_low) state_d = S_PRESS_DB;
      end
      S_PRESS_DB: begin
        if (steady_ok)        state_d = S_HELD;
        else if (press_abort) state_d = S_SCAN;
      end
      S_HELD: begin
        if (rows_idle) state_d = S_REL_DB;
      end
      S_REL_DB: begin
        if (steady_ok)       state_d = S_SCAN;
        else if (!rows_idle) state_d = S_HELD;
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_comb begin
    cnt_d          = cnt_q;
    col_idx_d      = col_idx_q;
    row_idx_d      = row_idx_q;
    db_en_d        = db_en_q;
    db_clear_d     = 1'b0;
    db_criterion_d = db_criterion_q;
    key_code_d     = key_code_q;
    key_valid_d    = 1'b0;
    key_held_d     = key_held_q;
    case (state_q)
      S_SCAN: begin
        db_en_d = 1'b0;
        if (!cnt_done) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (single_low) begin
          row_idx_d      = row_enc;
          db_criterion_d = rows_s_q;
          db_clear_d     = 1'b1;
          db_en_d        = 1'b1;
          cnt_d          = '0;
        end else begin
          col_idx_d = col_idx_q + 2'd1;
          cnt_d     = '0;
        end
      end
      S_PRESS_DB: begin
        if (steady_ok) begin
          key_code_d  = {row_idx_q, col_idx_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          db_en_d     = 1'b0;
        end else if (press_abort) begin
          db_clear_d = 1'b1;
          db_en_d    = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
          cnt_d      = '0;
        end
      end
      S_HELD: begin
        db_en_d = 1'b0;
        if (rows_idle) begin
          db_criterion_d = 4'b1111;
          db_clear_d     = 1'b1;
          db_en_d        = 1'b1;
        end
      end
      S_REL_DB: begin
        if (steady_ok) begin
          key_held_d = 1'b0;
          db_en_d    = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
          cnt_d      = '0;
        end else if (!rows_idle) begin
          db_en_d = 1'b0;
        end
      end
      default: begin
        db_en_d = 1'b0;
      end
    endcase
  end

  assign cols_n       = ~(4'b0001 << col_idx_q);
  assign db_en        = db_en_q;
  assign db_clear     = db_clear_q;
  assign db_criterion = db_criterion_q;
  assign db_period    = DEBOUNCE_CYCLES;
  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign key_held     = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a switch-matrix keypad model, a counting debouncer
// model (steady after 8 matching enabled cycles) and hand-timed checks at negedges.
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic        db_en;
  logic        db_clear;
  logic [3:0]  db_criterion;
  logic [31:0] db_period;
  logic        db_steady;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_CYCLES(32'd60000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rows_n      (rows_n),
    .cols_n      (cols_n),
    .db_en       (db_en),
    .db_clear    (db_clear),
    .db_criterion(db_criterion),
    .db_period   (db_period),
    .db_steady   (db_steady),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: key (r,c) at index r*4+c pulls row r low while column c is driven low.
  logic [15:0] pressed;
  logic        ovr_en;
  logic [3:0]  ovr_val;
  logic [3:0]  rows_model;
  always_comb begin
    rows_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_model[r] = 1'b0;
  end
  assign rows_n = ovr_en ? ovr_val : rows_model;

  logic [3:0] db_cnt;
  always @(posedge clk) begin
    if (reset || db_clear) db_cnt <= 4'd0;
    else if (db_en) begin
      if (rows_n != db_criterion) db_cnt <= 4'd0;
      else if (db_cnt != 4'd8)    db_cnt <= db_cnt + 4'd1;
    end
  end
  assign db_steady = (db_cnt == 4'd8);

  int   kv_count;
  logic kv_prev;
  logic kv_consec;
  initial begin
    kv_count  = 0;
    kv_prev   = 1'b0;
    kv_consec = 1'b0;
  end
  always @(posedge clk) begin
    if (key_valid) kv_count <= kv_count + 1;
    if (key_valid && kv_prev) kv_consec <= 1'b1;
    kv_prev <= key_valid;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cols_n"},       32'(cols_n),       32'h0000_000E);
    check({tag, "_db_en"},        32'(db_en),        32'h0);
    check({tag, "_db_clear"},     32'(db_clear),     32'h1);
    check({tag, "_db_criterion"}, 32'(db_criterion), 32'h0000_000F);
    check({tag, "_key_code"},     32'(key_code),     32'h0);
    check({tag, "_key_valid"},    32'(key_valid),    32'h0);
    check({tag, "_key_held"},     32'(key_held),     32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed no end of test, required end before 20000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    pressed = 16'h0000;
    ovr_en  = 1'b0;
    ovr_val = 4'b1111;
    tick(3);
    check_reset_values("por");
    check("por_db_period", db_period, 32'd60000);
    $display("step power_on_reset checked");
    reset = 1'b0;

    // Idle scan: 5 cycles per column, wrapping after column 3.
    check("idle_col0_start", 32'(cols_n), 32'hE);
    tick(1);
    check("idle_clear_drop", 32'(db_clear), 32'h0);
    check("idle_db_en",      32'(db_en),    32'h0);
    tick(3);
    check("idle_col0_end",   32'(cols_n), 32'hE);
    tick(1);
    check("idle_col1",       32'(cols_n), 32'hD);
    tick(5);
    check("idle_col2",       32'(cols_n), 32'hB);
    tick(5);
    check("idle_col3",       32'(cols_n), 32'h7);
    tick(5);
    check("idle_wrap",       32'(cols_n), 32'hE);
    check("idle_no_valid",   32'(kv_count), 32'd0);
    $display("step idle_scan checked");

    // Clean press of row2/col1.
    pressed[9] = 1'b1;
    tick(10);
    check("press_clear",     32'(db_clear),     32'h1);
    check("press_db_en",     32'(db_en),        32'h1);
    check("press_criterion", 32'(db_criterion), 32'hB);
    check("press_cols",      32'(cols_n),       32'hD);
    tick(10);
    check("press_valid",     32'(key_valid), 32'h1);
    check("press_code",      32'(key_code),  32'h9);
    check("press_held",      32'(key_held),  32'h1);
    check("press_en_off",    32'(db_en),     32'h0);
    tick(1);
    check("press_valid_end", 32'(key_valid), 32'h0);
    $display("step clean_press row2 col1 checked");

    // Release bounce: release, then re-press as the release debounce starts.
    tick(4);
    pressed[9] = 1'b0;
    tick(3);
    check("relb_clear",      32'(db_clear),     32'h1);
    check("relb_criterion",  32'(db_criterion), 32'hF);
    check("relb_db_en",      32'(db_en),        32'h1);
    check("relb_held",       32'(key_held),     32'h1);
    pressed[9] = 1'b1;
    tick(1);
    check("relb_clear_end",  32'(db_clear), 32'h0);
    tick(2);
    check("relb_back_en",    32'(db_en),    32'h0);
    check("relb_back_held",  32'(key_held), 32'h1);
    check("relb_back_cols",  32'(cols_n),   32'hD);
    $display("step release_bounce checked");

    // Clean release: key_held falls, scanning resumes at column 2.
    tick(4);
    pressed[9] = 1'b0;
    tick(12);
    check("rel_held_before", 32'(key_held), 32'h1);
    tick(1);
    check("rel_held_after",  32'(key_held), 32'h0);
    check("rel_next_col",    32'(cols_n),   32'hB);
    check("rel_db_en",       32'(db_en),    32'h0);
    check("rel_one_valid",   32'(kv_count), 32'd1);
    $display("step clean_release checked");

    // Press bounce: row0 low for 3 cycles around the column-2 sample point.
    tick(2);
    ovr_en  = 1'b1;
    ovr_val = 4'b1110;
    tick(3);
    check("bnc_clear",       32'(db_clear),     32'h1);
    check("bnc_db_en",       32'(db_en),        32'h1);
    check("bnc_criterion",   32'(db_criterion), 32'hE);
    check("bnc_cols",        32'(cols_n),       32'hB);
    ovr_en = 1'b0;
    tick(2);
    check("bnc_wait_clear",  32'(db_clear), 32'h0);
    check("bnc_wait_en",     32'(db_en),    32'h1);
    tick(1);
    check("bnc_abort_clear", 32'(db_clear), 32'h1);
    check("bnc_abort_en",    32'(db_en),    32'h0);
    check("bnc_next_col",    32'(cols_n),   32'h7);
    tick(1);
    check("bnc_clear_end",   32'(db_clear), 32'h0);
    $display("step press_bounce checked");

    // Ghost: rows 1 and 2 both low in column 2.
    pressed[6]  = 1'b1;
    pressed[10] = 1'b1;
    tick(18);
    check("ghost_col2",      32'(cols_n),   32'hB);
    check("ghost_no_clear",  32'(db_clear), 32'h0);
    tick(1);
    check("ghost_advance",   32'(cols_n),   32'h7);
    check("ghost_clear_idle",32'(db_clear), 32'h0);
    check("ghost_db_en",     32'(db_en),    32'h0);
    check("ghost_no_valid",  32'(kv_count), 32'd1);
    $display("step ghost checked");

    // Press row3/col0, then reset while it is held.
    pressed    = 16'h0000;
    pressed[12] = 1'b1;
    tick(10);
    check("r3_clear",        32'(db_clear),     32'h1);
    check("r3_criterion",    32'(db_criterion), 32'h7);
    check("r3_cols",         32'(cols_n),       32'hE);
    tick(10);
    check("r3_valid",        32'(key_valid), 32'h1);
    check("r3_code",         32'(key_code),  32'hC);
    check("r3_held",         32'(key_held),  32'h1);
    tick(1);
    check("r3_valid_end",    32'(key_valid), 32'h0);
    reset = 1'b1;
    tick(1);
    check_reset_values("held_rst");
    reset = 1'b0;
    tick(5);
    check("redet_clear",     32'(db_clear),     32'h1);
    check("redet_criterion", 32'(db_criterion), 32'h7);
    check("redet_cols",      32'(cols_n),       32'hE);
    check("redet_db_en",     32'(db_en),        32'h1);
    tick(10);
    check("redet_valid",     32'(key_valid), 32'h1);
    check("redet_code",      32'(key_code),  32'hC);
    check("redet_held",      32'(key_held),  32'h1);
    tick(1);
    check("redet_valid_end", 32'(key_valid), 32'h0);
    check("total_valids",    32'(kv_count),  32'd3);
    check("no_back_to_back", 32'(kv_consec), 32'h0);
    $display("step reset_in_held checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
